// File: rtl/stack_pkg.sv
// Shared definitions for the hardware LIFO: default geometry and FSM encoding.
package stack_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

endpackage : stack_pkg

// File: rtl/stack_unit_if.sv
// CPU-side request/response bundle of the stack unit.
interface stack_unit_if
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              pop_done;
  logic              push_done;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;

  // CPU control unit side
  modport master (
    output push, pop, data_in, err_clr,
    input  data_out, pop_done, push_done, busy, count, full, empty,
           overflow_err, underflow_err
  );

  // Stack unit side
  modport slave (
    input  push, pop, data_in, err_clr,
    output data_out, pop_done, push_done, busy, count, full, empty,
           overflow_err, underflow_err
  );

endinterface : stack_unit_if

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, combinational read, contents never reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : stack_ram

// File: rtl/stack_unit.sv
// Hardware LIFO for the CPU: push/pop/swap-top handling, occupancy tracking,
// sticky error flags and one-cycle completion pulses.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2 ** ADDR_W);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rd_data_p0;
  logic [DATA_W-1:0] data_out_q;
  logic              pop_done_q;
  logic              push_done_q;
  logic              ovf_q;
  logic              udf_q;

  logic              full_w;
  logic              empty_w;
  logic              idle_w;
  logic              do_push;
  logic              do_pop;
  logic              do_swap;
  logic              ovf_set;
  logic              udf_set;
  logic [ADDR_W-1:0] top_addr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_rdata;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c == DEPTH) ? c : c + (ADDR_W+1)'(1);
  endfunction

  function automatic logic [ADDR_W:0] sat_dec(input logic [ADDR_W:0] c);
    return (c == '0) ? c : c - (ADDR_W+1)'(1);
  endfunction

  assign full_w  = (count == DEPTH);
  assign empty_w = (count == '0);
  // Low address bits of count-1 still point at the top entry when full.
  assign top_addr = count[ADDR_W-1:0] - ADDR_W'(1);

  always_comb begin
    idle_w  = (state == ST_IDLE);
    do_swap = idle_w & bus.push & bus.pop & ~empty_w;
    // A push+pop on an empty stack degrades to a plain push.
    do_push = idle_w & bus.push & ((~bus.pop & ~full_w) | (bus.pop & empty_w));
    do_pop  = idle_w & bus.pop & ~bus.push & ~empty_w;
    ovf_set = idle_w & bus.push & ~bus.pop & full_w;
    udf_set = idle_w & bus.pop & empty_w;
    ram_we    = do_push | do_swap;
    ram_waddr = do_swap ? top_addr : count[ADDR_W-1:0];
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.data_in),
    .raddr (top_addr),
    .rdata (ram_rdata)
  );

  // Stage p0: top value captured at the request edge, before any swap write lands.
  always_ff @(posedge clk) begin
    if (do_pop | do_swap) begin
      rd_data_p0 <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      data_out_q  <= '0;
      pop_done_q  <= 1'b0;
      push_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      pop_done_q  <= 1'b0;
      push_done_q <= do_push | do_swap;
      // Clear and set in the same cycle: set wins.
      ovf_q <= (ovf_q & ~bus.err_clr) | ovf_set;
      udf_q <= (udf_q & ~bus.err_clr) | udf_set;
      case (state)
        ST_IDLE: begin
          if (do_push) begin
            count <= sat_inc(count);
          end else if (do_pop) begin
            count <= sat_dec(count);
          end
          if (do_pop | do_swap) begin
            state <= ST_RD;
          end
        end
        ST_RD: begin
          data_out_q <= rd_data_p0;
          pop_done_q <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.pop_done      = pop_done_q;
  assign bus.push_done     = push_done_q;
  assign bus.busy          = (state == ST_RD);
  assign bus.count         = count;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed vector table, hand sequences
// for fill/overflow and reset-mid-pop, and randomized traffic against a queue model.
module tb_stack_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stack_unit_if #(.DATA_W(16), .ADDR_W(4)) b ();

  stack_unit #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic        clr;
    logic [4:0]  e_count;
    logic [15:0] e_dout;
    logic        e_pop_done;
    logic        e_push_done;
    logic        e_busy;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [15:0] m_stk[$];
  logic        m_busy;
  logic [15:0] m_pend;
  logic [15:0] m_dout;
  logic        m_pop_done;
  logic        m_push_done;
  logic        m_ovf;
  logic        m_udf;

  task automatic chk(input string nm, input logic [4:0] c, input logic [15:0] dout,
                     input logic pd, input logic psd, input logic bsy,
                     input logic ov, input logic ud);
    logic [27:0] act;
    logic [27:0] exp;
    exp = {c, (c == 5'd16), (c == 5'd0), bsy, pd, psd, ov, ud, dout};
    act = {b.count, b.full, b.empty, b.busy, b.pop_done, b.push_done,
           b.overflow_err, b.underflow_err, b.data_out};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d full=%b empty=%b busy=%b pd=%b psd=%b ovf=%b udf=%b dout=%h | want cnt=%0d full=%b empty=%b busy=%b pd=%b psd=%b ovf=%b udf=%b dout=%h",
               nm, act[27:23], act[22], act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
               exp[27:23], exp[22], exp[21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic drive(input logic ps, input logic pp, input logic [15:0] d, input logic c);
    b.push    = ps;
    b.pop     = pp;
    b.data_in = d;
    b.err_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic ps, input logic pp, input logic [15:0] d,
                     input logic c, input logic [4:0] ec, input logic [15:0] ed,
                     input logic epd, input logic epsd, input logic eb,
                     input logic eo, input logic eu);
    vec_t v;
    v.name = nm; v.push = ps; v.pop = pp; v.din = d; v.clr = c;
    v.e_count = ec; v.e_dout = ed; v.e_pop_done = epd; v.e_push_done = epsd;
    v.e_busy = eb; v.e_ovf = eo; v.e_udf = eu;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_busy = 0; m_pend = '0; m_dout = '0;
    m_pop_done = 0; m_push_done = 0; m_ovf = 0; m_udf = 0;
  endtask

  // LIFO semantics from the request rules, one clock edge per call.
  task automatic model_step(input logic ps, input logic pp, input logic [15:0] d, input logic c);
    logic ovs, uds;
    ovs = 0; uds = 0;
    m_pop_done = 0; m_push_done = 0;
    if (m_busy) begin
      m_dout = m_pend;
      m_pop_done = 1;
      m_busy = 0;
    end else if (ps && !pp) begin
      if (m_stk.size() < 16) begin
        m_stk.push_back(d);
        m_push_done = 1;
      end else ovs = 1;
    end else if (pp && !ps) begin
      if (m_stk.size() > 0) begin
        m_pend = m_stk.pop_back();
        m_busy = 1;
      end else uds = 1;
    end else if (ps && pp) begin
      if (m_stk.size() > 0) begin
        m_pend = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = d;
        m_busy = 1;
        m_push_done = 1;
      end else begin
        m_stk.push_back(d);
        m_push_done = 1;
        uds = 1;
      end
    end
    m_ovf = (m_ovf && !c) || ovs;
    m_udf = (m_udf && !c) || uds;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(0, 0, '0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 5'd0, 16'h0000, 0, 0, 0, 0, 0);
    rst = 1'b1;

    //  name           ps pp din      clr cnt dout     pd psd bsy ovf udf
    add("push_1234",   1, 0, 16'h1234, 0, 1, 16'h0000, 0, 1, 0, 0, 0);
    add("push_5678",   1, 0, 16'h5678, 0, 2, 16'h0000, 0, 1, 0, 0, 0);
    add("idle_2",      0, 0, 16'h0000, 0, 2, 16'h0000, 0, 0, 0, 0, 0);
    add("pop1_req",    0, 1, 16'h0000, 0, 1, 16'h0000, 0, 0, 1, 0, 0);
    add("pop1_done",   0, 0, 16'h0000, 0, 1, 16'h5678, 1, 0, 0, 0, 0);
    add("pop2_req",    0, 1, 16'h0000, 0, 0, 16'h5678, 0, 0, 1, 0, 0);
    add("pop2_done",   0, 0, 16'h0000, 0, 0, 16'h1234, 1, 0, 0, 0, 0);
    add("pop_empty",   0, 1, 16'h0000, 0, 0, 16'h1234, 0, 0, 0, 0, 1);
    add("udf_sticky",  0, 0, 16'h0000, 0, 0, 16'h1234, 0, 0, 0, 0, 1);
    add("udf_clr",     0, 0, 16'h0000, 1, 0, 16'h1234, 0, 0, 0, 0, 0);
    add("push_aaaa",   1, 0, 16'hAAAA, 0, 1, 16'h1234, 0, 1, 0, 0, 0);
    add("swap_req",    1, 1, 16'hBBBB, 0, 1, 16'h1234, 0, 1, 1, 0, 0);
    add("swap_done",   0, 0, 16'h0000, 0, 1, 16'hAAAA, 1, 0, 0, 0, 0);
    add("pop_bbbb",    0, 1, 16'h0000, 0, 0, 16'hAAAA, 0, 0, 1, 0, 0);
    add("pop_bbbb_d",  0, 0, 16'h0000, 0, 0, 16'hBBBB, 1, 0, 0, 0, 0);
    add("swap_empty",  1, 1, 16'hCCCC, 0, 1, 16'hBBBB, 0, 1, 0, 0, 1);
    add("pop_cccc",    0, 1, 16'h0000, 0, 0, 16'hBBBB, 0, 0, 1, 0, 1);
    add("rd_clr_ign",  0, 1, 16'h0000, 1, 0, 16'hCCCC, 1, 0, 0, 0, 0);
    add("clr_set_win", 0, 1, 16'h0000, 1, 0, 16'hCCCC, 0, 0, 0, 0, 1);
    add("udf_clr2",    0, 0, 16'h0000, 1, 0, 16'hCCCC, 0, 0, 0, 0, 0);
    add("push_1111",   1, 0, 16'h1111, 0, 1, 16'hCCCC, 0, 1, 0, 0, 0);
    add("pop_1111",    0, 1, 16'h0000, 0, 0, 16'hCCCC, 0, 0, 1, 0, 0);
    add("push_in_rd",  1, 0, 16'h2222, 0, 0, 16'h1111, 1, 0, 0, 0, 0);
    add("after_rd",    0, 0, 16'h0000, 0, 0, 16'h1111, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
      tick();
      chk(vecs[i].name, vecs[i].e_count, vecs[i].e_dout, vecs[i].e_pop_done,
          vecs[i].e_push_done, vecs[i].e_busy, vecs[i].e_ovf, vecs[i].e_udf);
    end

    // Fill to capacity, then overflow
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 16'(i), 0);
      tick();
      chk("fill", 5'(i + 1), 16'h1111, 0, 1, 0, 0, 0);
    end
    drive(1, 0, 16'hFFFF, 0);
    tick();
    chk("overflow", 5'd16, 16'h1111, 0, 0, 0, 1, 0);
    drive(0, 1, 16'h0000, 0);
    tick();
    chk("pop_full_req", 5'd15, 16'h1111, 0, 0, 1, 1, 0);
    drive(0, 0, 16'h0000, 0);
    tick();
    chk("pop_full_done", 5'd15, 16'h000F, 1, 0, 0, 1, 0);
    drive(0, 0, 16'h0000, 1);
    tick();
    chk("ovf_clr", 5'd15, 16'h000F, 0, 0, 0, 0, 0);

    // Reset in the middle of a pop
    drive(0, 1, 16'h0000, 0);
    tick();
    chk("pop_before_rst", 5'd14, 16'h000F, 0, 0, 1, 0, 0);
    drive(0, 0, 16'h0000, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", 5'd0, 16'h0000, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    tick();
    chk("no_pop_done", 5'd0, 16'h0000, 0, 0, 0, 0, 0);

    // Randomized traffic against the queue model
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic ps, pp, c;
      logic [15:0] d;
      int pw;
      pw = ((i / 300) % 2 == 0) ? 70 : 30;
      ps = ($urandom_range(99) < pw);
      pp = ($urandom_range(99) < 100 - pw);
      c  = ($urandom_range(99) < 5);
      d  = 16'($urandom);
      drive(ps, pp, d, c);
      model_step(ps, pp, d, c);
      tick();
      chk("random", 5'(m_stk.size()), m_dout, m_pop_done, m_push_done, m_busy, m_ovf, m_udf);
    end

    drive(0, 0, '0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stack_unit
